alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Registered, handshaked integer ALU for the execute stage. Generalises the combinational ALU:
//  parametrised width, valid/ready flow control on both sides, NZCV flags, shifts, and an
//  iterative shift-add multiplier (MUL/MULHU). Single-cycle ops sustain 1 op/clk.
//  Multiplies take DATA_WIDTH clocks.
// PARAMETERS
//  DATA_WIDTH  64                   operand/result width, >= 8
//  SHIFT_AMT   $clog2(DATA_WIDTH)   shift-amount width; also the multiply counter width
// PORTS
//  clk         in   1            single clock, rising edge
//  rst_n       in   1            asynchronous, active-low reset
//  in_valid    in   1            operation presented
//  in_ready    out  1            block can accept; a transfer occurs when in_valid & in_ready
//  data_in_a   in   DATA_WIDTH   operand A
//  data_in_b   in   DATA_WIDTH   operand B
//  shift_code  in   SHIFT_AMT    shift amount for SLL/SRL/SRA
//  func_code   in   5            operation select
//  out_valid   out  1            result register holds a result
//  out_ready   in   1            consumer accepts; a transfer occurs when out_valid & out_ready
//  data_out    out  DATA_WIDTH   result
//  flags       out  4            {N,Z,C,V} for data_out
//  illegal     out  1            result came from an undefined func_code
// BEHAVIOUR
//  Reset: in_ready=0 while rst_n=0, and 1 on the first clk after release. out_valid=0,
//   data_out=0, flags=0, illegal=0, state=IDLE, counter=0. Asserting reset aborts any operation.
//  func_code: 00000 ADD, 00001 SUB (A-B), 00010 XOR, 00011 AND, 00100 OR, 00101 SLTU, 00110 SLT,
//   00111 NEG (0-A), 01000 SLL, 01001 SRL, 01010 SRA, 01011 MUL (low half), 01100 MULHU
//   (unsigned high half). All other codes: result 0, illegal=1.
//  Width rules: all arithmetic is modulo 2^DATA_WIDTH. SLT/SLTU give 1 or 0, zero-extended.
//   Shifts use shift_code only; data_in_b is ignored for shifts.
//  Flags: N=data_out[MSB], Z=(data_out==0).
//   ADD: C=carry out; V=signed overflow.
//   SUB/NEG: C=borrow (unsigned A<B; for NEG, A!=0); V=signed overflow (NEG: A==min).
//   All other ops: C=V=0.
//  in_ready = (state==IDLE) & (~out_valid | out_ready), registered-free (combinational from state).
//  FSM:
//   IDLE  accept non-MUL -> result, flags, illegal registered at the next edge, out_valid=1
//         (latency 1). Accept MUL/MULHU -> latch A, B, op; clear the 2*DATA_WIDTH accumulator;
//         counter=0; go to MUL.
//   MUL   per clk: if B[counter], add A<<counter into the accumulator; counter++.
//         At counter==DATA_WIDTH-1 the add completes. If the output is free (~out_valid |
//         out_ready), load data_out from the accumulator (low or high half), out_valid=1,
//         go to IDLE. Otherwise go to MWAIT.
//   MWAIT accumulator frozen. When ~out_valid | out_ready, load data_out, out_valid=1, go to IDLE.
//  Multiply latency: out_valid rises DATA_WIDTH clocks after accept when unstalled.
//   in_ready=0 throughout MUL and MWAIT.
//  Output hold: while out_valid & ~out_ready, data_out, flags and illegal are stable.
//   out_valid falls after the transfer unless a new result loads on the same edge
//   (back-to-back, no bubble).
//  in_valid while in_ready=0 is ignored; the upstream stage holds its operands.
//  Counter wraps only via the FSM. It never exceeds DATA_WIDTH-1.
// TESTING (DATA_WIDTH=64)
//  1 ADD A=FFFF_FFFF_FFFF_FFFF B=1, out_ready=1 -> next clk out_valid=1, data_out=0,
//    flags N0 Z1 C1 V0.
//  2 SUB A=8000_0000_0000_0000 B=1 -> data_out=7FFF_FFFF_FFFF_FFFF, flags N0 Z0 C0 V1;
//    NEG A=0 -> 0, Z1 C0 V0.
//  3 MUL A=0000_0001_0000_0001 B=3 -> in_ready=0 for 64 clks, then data_out=0000_0003_0000_0003;
//    MULHU A=B=FFFF_FFFF_FFFF_FFFF -> FFFF_FFFF_FFFF_FFFE.
//  4 out_ready=0: ADD 5+7 accepted, then second op presented -> in_ready=0, data_out=0xC held
//    for 5 clks; raise out_ready -> second op accepted the same clk, result on the next clk
//    with no bubble.
//  5 SRA A=8000_0000_0000_0000 shift_code=4 -> F800_0000_0000_0000, N1; SRL same -> 0800_..._0000;
//    func_code=11111 -> data_out 0, illegal=1.
//  6 rst_n=0 at clk 10 of a MUL -> out_valid=0 immediately; after release in_ready=1 and the next
//    ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_seq_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if
//   Operand and result channels of the sequential ALU.
//
//   Handshake (both channels): a transfer happens on a rising clk edge where
//   valid & ready are both high. The producer holds valid and its payload
//   stable until that edge. The consumer may raise or drop ready at any time.
//   The producer never waits for ready before raising valid.
//
//   Operand channel (master -> slave):
//     in_valid, data_in_a, data_in_b, shift_code, func_code   ; in_ready back
//   Result channel (slave -> master):
//     out_valid, data_out, flags {N,Z,C,V}, illegal           ; out_ready back
// ----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int DATA_WIDTH = 64,
    parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in_a;
    logic [DATA_WIDTH-1:0] data_in_b;
    logic [SHIFT_AMT-1:0]  shift_code;
    logic [4:0]            func_code;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic [3:0]            flags;
    logic                  illegal;

    // Upstream stage / consumer side.
    modport master (
        output in_valid, data_in_a, data_in_b, shift_code, func_code, out_ready,
        input  in_ready, out_valid, data_out, flags, illegal
    );

    // ALU side.
    modport slave (
        input  in_valid, data_in_a, data_in_b, shift_code, func_code, out_ready,
        output in_ready, out_valid, data_out, flags, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//   Registered, handshaked integer ALU for the execute stage. Single-cycle ops
//   (add/sub/logic/compare/neg/shifts) register their result one clock after
//   acceptance and sustain one op per clock. MUL/MULHU use an iterative
//   shift-add multiplier that takes DATA_WIDTH clocks.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any multiply in flight
//   bus          alu_seq_if.slave: operand channel in, result channel out
//   dbg_state_o  current FSM state (IDLE / MUL / MWAIT) for observation
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state_o
);
    localparam int W = DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_MWAIT = 2'd2;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_NEG   = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_MUL   = 5'b01011;
    localparam logic [4:0] OP_MULHU = 5'b01100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q, state_d;
    logic [SHIFT_AMT-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         mul_a_q, mul_b_q;
    logic                 mul_hi_q;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         data_q, data_d;
    logic [3:0]           flags_q, flags_d;
    logic                 illegal_q, illegal_d;
    // Low during reset and for the first clock after release so in_ready
    // stays low until the block has seen a clock edge out of reset.
    logic                 init_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_free;
    logic in_ready;
    logic accept;
    logic is_mul;

    assign out_free = ~out_valid_q | bus.out_ready;
    assign in_ready = init_q & (state_q == ST_IDLE) & out_free;
    assign accept   = bus.in_valid & in_ready;
    assign is_mul   = (bus.func_code == OP_MUL) | (bus.func_code == OP_MULHU);

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [W-1:0] op_a, op_b;
    logic [W:0]   add_w, sub_w, neg_w;
    logic [W-1:0] alu_res;
    logic         alu_c, alu_v, alu_ill;

    assign op_a  = bus.data_in_a;
    assign op_b  = bus.data_in_b;
    // Bit W of sub_w / neg_w is the borrow out of the W-bit subtraction.
    assign add_w = {1'b0, op_a} + {1'b0, op_b};
    assign sub_w = {1'b0, op_a} - {1'b0, op_b};
    assign neg_w = {(W+1){1'b0}} - {1'b0, op_a};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (bus.func_code)
            OP_ADD: begin
                alu_res = add_w[W-1:0];
                alu_c   = add_w[W];
                alu_v   = (op_a[W-1] == op_b[W-1]) && (add_w[W-1] != op_a[W-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[W-1:0];
                alu_c   = sub_w[W];
                alu_v   = (op_a[W-1] != op_b[W-1]) && (sub_w[W-1] != op_a[W-1]);
            end
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLTU: alu_res = {{(W-1){1'b0}}, sub_w[W]};
            OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_NEG: begin
                alu_res = neg_w[W-1:0];
                alu_c   = neg_w[W];
                // Only the most negative value overflows on negation.
                alu_v   = op_a[W-1] & ~(|op_a[W-2:0]);
            end
            OP_SLL:  alu_res = op_a << bus.shift_code;
            OP_SRL:  alu_res = op_a >> bus.shift_code;
            OP_SRA:  alu_res = $signed(op_a) >>> bus.shift_code;
            OP_MUL, OP_MULHU: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiplier
    // ------------------------------------------------------------------
    logic           cnt_last;
    logic [2*W-1:0] addend, acc_sum, mul_src;
    logic [W-1:0]   mul_res;

    assign cnt_last = (cnt_q == SHIFT_AMT'(W - 1));
    assign addend   = mul_b_q[cnt_q] ? ({{W{1'b0}}, mul_a_q} << cnt_q) : '0;
    assign acc_sum  = acc_q + addend;
    // In MUL the final partial product is folded in on the same edge that
    // loads the result; in MWAIT the accumulator already holds the product.
    assign mul_src  = (state_q == ST_MUL) ? acc_sum : acc_q;
    assign mul_res  = mul_hi_q ? mul_src[2*W-1:W] : mul_src[W-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic load_alu, load_mul, mul_start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = ST_MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d = acc_sum;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (out_free) begin
                        load_mul = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_MWAIT;
                    end
                end else begin
                    cnt_d = cnt_q + SHIFT_AMT'(1);
                end
            end
            ST_MWAIT: begin
                if (out_free) begin
                    load_mul = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register: a new load on the same edge as a drain keeps
    // out_valid high with no bubble.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q & ~bus.out_ready;
        data_d      = data_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        if (load_alu) begin
            out_valid_d = 1'b1;
            data_d      = alu_res;
            flags_d     = {alu_res[W-1], (alu_res == '0), alu_c, alu_v};
            illegal_d   = alu_ill;
        end else if (load_mul) begin
            out_valid_d = 1'b1;
            data_d      = mul_res;
            flags_d     = {mul_res[W-1], (mul_res == '0), 2'b00};
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            init_q      <= 1'b1;
            if (mul_start) begin
                mul_a_q  <= bus.data_in_a;
                mul_b_q  <= bus.data_in_b;
                mul_hi_q <= (bus.func_code == OP_MULHU);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.flags     = flags_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
//   Directed steps followed by randomized operations. Expected results come
//   from an arithmetic reference model; a scoreboard queue matches them to
//   results in transfer order, and stalled outputs are checked for stability.
// ----------------------------------------------------------------------------
module tb_alu_seq;
    localparam int W  = 64;
    localparam int SA = 6;

    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [68:0] exp_q[$];

    alu_seq_if #(.DATA_WIDTH(W), .SHIFT_AMT(SA)) bus ();

    alu_seq #(.DATA_WIDTH(W), .SHIFT_AMT(SA)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {illegal, N, Z, C, V, result}.
    function automatic logic [68:0] model(input logic [4:0] f, input logic [63:0] a,
                                          input logic [63:0] b, input logic [5:0] sh);
        logic [63:0]        r;
        logic               c, v, ill;
        logic [64:0]        u;
        logic signed [65:0] sa, sb, s;
        logic [127:0]       p;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        sa  = $signed({{2{a[63]}}, a});
        sb  = $signed({{2{b[63]}}, b});
        p   = {64'd0, a} * {64'd0, b};
        case (f)
            5'd0: begin
                u = {1'b0, a} + {1'b0, b};
                r = u[63:0];
                c = u[64];
                s = sa + sb;
                v = (s > SMAX) || (s < SMIN);
            end
            5'd1: begin
                r = a - b;
                c = (a < b);
                s = sa - sb;
                v = (s > SMAX) || (s < SMIN);
            end
            5'd2: r = a ^ b;
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = (a < b) ? 64'd1 : 64'd0;
            5'd6: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd7: begin
                r = 64'd0 - a;
                c = (a != 64'd0);
                s = -sa;
                v = (s > SMAX) || (s < SMIN);
            end
            5'd8:  r = a << sh;
            5'd9:  r = a >> sh;
            5'd10: r = $signed(a) >>> sh;
            5'd11: r = p[63:0];
            5'd12: r = p[127:64];
            default: ill = 1'b1;
        endcase
        return {ill, r[63], (r == 64'd0), c, v, r};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic        stall_p = 1'b0;
    logic [68:0] held_p;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            check("state_known", $isunknown(dbg_state), 1'b0);
            if (stall_p) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_payload", {bus.illegal, bus.flags, bus.data_out}, held_p);
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.func_code, bus.data_in_a, bus.data_in_b, bus.shift_code));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_result", 1'b1, 1'b0);
                else
                    check("scoreboard", {bus.illegal, bus.flags, bus.data_out}, exp_q.pop_front());
            end
            stall_p = bus.out_valid && !bus.out_ready;
            held_p  = {bus.illegal, bus.flags, bus.data_out};
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one op, waits for acceptance, then drops in_valid.
    // Returns at #1 after the accepting edge.
    task automatic drive_op(input logic [4:0] f, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] sh, input bit rnd);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.func_code  = f;
        bus.data_in_a  = a;
        bus.data_in_b  = b;
        bus.shift_code = sh;
        bus.in_valid   = 1'b1;
        if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Waits (bounded) for out_valid; edges = clock edges after the accepting
    // edge, rdy_low = cycles with in_ready low meanwhile.
    task automatic wait_result(output int edges, output int rdy_low);
        edges   = 0;
        rdy_low = 0;
        @(negedge clk);
        while (!bus.out_valid && edges < 300) begin
            if (!bus.in_ready) rdy_low++;
            edges++;
            @(negedge clk);
        end
        if (edges >= 300) check("result_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int          lat;
        int          low;
        int          n;
        logic [4:0]  f;
        int          r;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.data_in_a  = '0;
        bus.data_in_b  = '0;
        bus.shift_code = '0;
        bus.func_code  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_data_out", bus.data_out, 64'd0);
        check("rst_flags", bus.flags, 4'd0);
        check("rst_illegal", bus.illegal, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_clk", bus.in_ready, 1'b0);
        @(negedge clk);
        check("ready_after_first_clk", bus.in_ready, 1'b1);

        // ADD wrap to zero
        drive_op(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0);
        wait_result(lat, low);
        check("add_latency", lat, 0);
        check("add_data", bus.data_out, 64'd0);
        check("add_flags", bus.flags, 4'b0110);

        // SUB signed overflow, NEG of zero
        drive_op(5'd1, 64'h8000_0000_0000_0000, 64'd1, 6'd0, 1'b0);
        wait_result(lat, low);
        check("sub_data", bus.data_out, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_flags", bus.flags, 4'b0001);
        drive_op(5'd7, 64'd0, 64'd0, 6'd0, 1'b0);
        wait_result(lat, low);
        check("neg0_data", bus.data_out, 64'd0);
        check("neg0_flags", bus.flags, 4'b0100);

        // MUL low half, MULHU high half
        drive_op(5'd11, 64'h0000_0001_0000_0001, 64'd3, 6'd0, 1'b0);
        wait_result(lat, low);
        check("mul_latency", lat, 64);
        check("mul_ready_low", low, 64);
        check("mul_data", bus.data_out, 64'h0000_0003_0000_0003);
        drive_op(5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0);
        wait_result(lat, low);
        check("mulhu_data", bus.data_out, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulhu_flags", bus.flags, 4'b1000);

        // Back-pressure: held result, then back-to-back with no bubble
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive_op(5'd0, 64'd5, 64'd7, 6'd0, 1'b0);
        bus.func_code = 5'd1;
        bus.data_in_a = 64'd9;
        bus.data_in_b = 64'd4;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_data", bus.data_out, 64'hC);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 1'b1);
        check("b2b_data", bus.data_out, 64'd5);

        // Illegal code, arithmetic and logical right shifts
        drive_op(5'b11111, 64'h1234, 64'h5678, 6'd3, 1'b0);
        wait_result(lat, low);
        check("illegal_data", bus.data_out, 64'd0);
        check("illegal_flag", bus.illegal, 1'b1);
        drive_op(5'd10, 64'h8000_0000_0000_0000, 64'hDEAD, 6'd4, 1'b0);
        wait_result(lat, low);
        check("sra_data", bus.data_out, 64'hF800_0000_0000_0000);
        check("sra_flags", bus.flags, 4'b1000);
        check("sra_legal", bus.illegal, 1'b0);
        drive_op(5'd9, 64'h8000_0000_0000_0000, 64'hDEAD, 6'd4, 1'b0);
        wait_result(lat, low);
        check("srl_data", bus.data_out, 64'h0800_0000_0000_0000);

        // Reset in the middle of a multiply
        drive_op(5'd11, rand_operand(), rand_operand(), 6'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b0);
        check("abort_data_out", bus.data_out, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_ready_after", bus.in_ready, 1'b1);
        drive_op(5'd0, 64'd1, 64'd1, 6'd0, 1'b0);
        wait_result(lat, low);
        check("post_abort_add", bus.data_out, 64'd2);
        check("post_abort_flags", bus.flags, 4'b0000);

        // Randomized operations with random back-pressure
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 16) f = 5'(r % 13);
            else         f = 5'($urandom_range(13, 31));
            drive_op(f, rand_operand(), rand_operand(), 6'($urandom_range(0, 63)), 1'b1);
        end

        // Drain
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        check("drain_out_valid", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
